// File: rtl/x_100_mod_997_stream_if.sv
// Valid/ready stream bundle for the mod-997 front/back end.
//   in_valid/in_ready/in_data/in_last : operand word stream into the block
//   out_valid/out_ready/out_residue    : residue stream out of the block
// master = stream source/sink side, slave = x_100_mod_997_stream side.
interface x_100_mod_997_stream_if #(
  parameter int unsigned WORD_W = 20,
  parameter int unsigned R_W    = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [R_W-1:0]    out_residue;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_residue
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_residue
  );
endinterface

// File: rtl/x_100_mod_997_stream.sv
// Streaming wrapper around an external combinational 100-bit mod-997 reducer.
// Assembles an operand from WORD_W-bit words (LS word first) onto x_out,
// captures the reducer's residue from r_in one cycle after the operand
// closes, and offers it on a valid/ready port. One operand in flight.
//   clk, rst_n : clock, synchronous active-low reset
//   strm       : slave side of the word/residue stream interface
//   x_out      : assembled operand to the reducer (registered)
//   r_in       : residue from the reducer
//   proto_err  : one-cycle pulse, operand ran past N_WORDS words
//   range_err  : sticky, a captured residue was >= MODULUS
module x_100_mod_997_stream #(
  parameter int unsigned WORD_W  = 20,
  parameter int unsigned N_WORDS = 5,
  parameter int unsigned R_W     = 10,
  parameter int unsigned MODULUS = 997
) (
  input  logic                        clk,
  input  logic                        rst_n,
  x_100_mod_997_stream_if.slave       strm,
  output logic [WORD_W*N_WORDS-1:0]   x_out,
  input  logic [R_W-1:0]              r_in,
  output logic                        proto_err,
  output logic                        range_err
);

  localparam int unsigned X_W   = WORD_W * N_WORDS;
  localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    REDUCE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [X_W-1:0]     x_d;
  logic [R_W-1:0]     residue_d;
  logic               out_valid_d;
  logic               in_ready_d;
  logic               proto_d;
  logic               range_d;
  logic               accept;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= COLLECT;
      idx              <= '0;
      x_out            <= '0;
      strm.out_residue <= '0;
      strm.out_valid   <= 1'b0;
      strm.in_ready    <= 1'b1;
      proto_err        <= 1'b0;
      range_err        <= 1'b0;
    end else begin
      state            <= state_d;
      idx              <= idx_d;
      x_out            <= x_d;
      strm.out_residue <= residue_d;
      strm.out_valid   <= out_valid_d;
      strm.in_ready    <= in_ready_d;
      proto_err        <= proto_d;
      range_err        <= range_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    x_d         = x_out;
    residue_d   = strm.out_residue;
    out_valid_d = strm.out_valid;
    proto_d     = 1'b0;
    range_d     = range_err;
    accept      = strm.in_valid && strm.in_ready;

    unique case (state)
      COLLECT: begin
        if (accept) begin
          // First word zero-extends: wipe stale upper slots of the last operand
          if (idx == '0) x_d = '0;
          for (int unsigned k = 0; k < N_WORDS; k++) begin
            if (idx == IDX_W'(k)) x_d[k*WORD_W +: WORD_W] = strm.in_data;
          end
          if (strm.in_last) begin
            state_d = REDUCE;
            idx_d   = '0;
          end else if (idx == IDX_W'(N_WORDS - 1)) begin
            // Operand full but not terminated: close it, discard the tail
            state_d = DRAIN;
            idx_d   = '0;
            proto_d = 1'b1;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (accept && strm.in_last) state_d = REDUCE;
      end
      REDUCE: begin
        // x_out has been stable for a full cycle, so r_in has settled
        residue_d   = r_in;
        out_valid_d = 1'b1;
        if (32'(r_in) >= MODULUS) range_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (strm.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    in_ready_d = (state_d == COLLECT) || (state_d == DRAIN);
  end

endmodule

// File: tb/tb_x_100_mod_997_stream.sv
// Scoreboard bench for x_100_mod_997_stream with a behavioural reducer.
module tb_x_100_mod_997_stream;

  logic        clk;
  logic        rst_n;
  logic [99:0] x_out;
  logic [9:0]  r_in;
  logic        proto_err;
  logic        range_err;
  logic        force_bad;

  x_100_mod_997_stream_if #(.WORD_W(20), .R_W(10)) bus ();

  x_100_mod_997_stream #(
    .WORD_W(20), .N_WORDS(5), .R_W(10), .MODULUS(997)
  ) dut (
    .clk(clk), .rst_n(rst_n), .strm(bus), .x_out(x_out),
    .r_in(r_in), .proto_err(proto_err), .range_err(range_err)
  );

  // Behavioural reducer: bit-serial long division, optionally forced bad
  function automatic logic [9:0] reduce(input logic [99:0] x);
    int unsigned r;
    r = 0;
    for (int i = 99; i >= 0; i--) r = (r * 2 + 32'(x[i])) % 997;
    return 10'(r);
  endfunction

  assign r_in = force_bad ? 10'd1000 : reduce(x_out);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [99:0] x;
    logic [9:0]  res;
    logic        rng;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          errors;
  int          proto_exp;
  int          proto_seen;
  logic        rng_model;
  int          rmode;        // 0: out_ready driven by directed code, 2: random
  logic [19:0] op_w[8];
  logic        prev_stall;
  logic [9:0]  prev_res;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Residue from words via precomputed powers of 2^20 mod 997
  function automatic logic [9:0] ref_res(input int n);
    longint unsigned r, p;
    r = 0;
    p = 1;
    for (int k = 0; k < n && k < 5; k++) begin
      r = (r + 64'(op_w[k]) * p) % 997;
      p = (p * 64'd1048576) % 997;
    end
    return 10'(r);
  endfunction

  task automatic send_word(input logic [19:0] d, input logic last, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 20'($urandom);
      bus.in_last  = 1'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
  endtask

  task automatic send_op(input int n, input int gapmax, input bit fixed, input logic [9:0] fres);
    exp_t e;
    e.x = '0;
    for (int k = 0; k < n && k < 5; k++) e.x[k*20 +: 20] = op_w[k];
    if (fixed)          e.res = fres;
    else if (force_bad) e.res = 10'd1000;
    else                e.res = ref_res(n);
    if (e.res >= 10'd997) rng_model = 1'b1;
    e.rng = rng_model;
    if (n > 5) proto_exp++;
    q.push_back(e);
    for (int k = 0; k < n; k++)
      send_word(op_w[k], k == n - 1, (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(negedge clk);
  endtask

  // Randomised downstream back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 2) bus.out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: scoreboard pop on transfer, hold-stability while stalled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (proto_err) proto_seen++;
        if (prev_stall) begin
          chk("hold_valid", 128'(bus.out_valid), 128'(1));
          chk("hold_residue", 128'(bus.out_residue), 128'(prev_res));
          chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got residue %0d expected none", bus.out_residue);
          end else begin
            e = q.pop_front();
            chk("residue", 128'(bus.out_residue), 128'(e.res));
            chk("x_out", 128'(x_out), 128'(e.x));
            chk("range_err", 128'(range_err), 128'(e.rng));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_res   = bus.out_residue;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    checks = 0; errors = 0; proto_exp = 0; proto_seen = 0;
    rng_model = 1'b0; rmode = 0; force_bad = 1'b0; prev_stall = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x_out", 128'(x_out), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_residue", 128'(bus.out_residue), 128'(0));
    chk("rst_proto", 128'(proto_err), 128'(0));
    chk("rst_range", 128'(range_err), 128'(0));
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));

    // Single word 1000: latency 2 cycles after acceptance
    op_w[0] = 20'd1000;
    q.push_back('{x: 100'd1000, res: 10'd3, rng: 1'b0});
    send_word(20'd1000, 1'b1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("lat_x_out", 128'(x_out), 128'(1000));
    chk("lat_valid_early", 128'(bus.out_valid), 128'(0));
    chk("lat_in_ready_reduce", 128'(bus.in_ready), 128'(0));
    @(negedge clk);
    chk("lat_valid", 128'(bus.out_valid), 128'(1));
    wait_drain();

    // X = 2^20 then X = 2^80; upper slots replaced
    op_w[0] = 0; op_w[1] = 1; op_w[2] = 0; op_w[3] = 0; op_w[4] = 0;
    send_op(5, 0, 1'b1, 10'd729);
    wait_drain();
    op_w[0] = 0; op_w[1] = 0; op_w[2] = 0; op_w[3] = 0; op_w[4] = 1;
    send_op(5, 0, 1'b1, 10'd603);
    wait_drain();

    // Back-pressure for 10 cycles
    bus.out_ready = 1'b0;
    op_w[0] = 20'd42;
    send_op(1, 0, 1'b1, 10'd42);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", 128'(bus.out_valid), 128'(1));
    repeat (10) begin
      @(negedge clk);
      chk("stall_residue", 128'(bus.out_residue), 128'(42));
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_xfer_valid", 128'(bus.out_valid), 128'(0));
    chk("post_xfer_in_ready", 128'(bus.in_ready), 128'(1));
    wait_drain();

    // Six words, last only on word 6: proto_err, tail discarded
    op_w[0] = 20'd997; op_w[1] = 0; op_w[2] = 0; op_w[3] = 0; op_w[4] = 0; op_w[5] = 20'd12345;
    send_op(6, 0, 1'b1, 10'd0);
    wait_drain();
    chk("proto_count_directed", 128'(proto_seen), 128'(1));

    // Reset mid-operand
    send_word(20'd111, 1'b0, 0);
    send_word(20'd222, 1'b0, 0);
    send_word(20'd333, 1'b0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_x_out", 128'(x_out), 128'(0));
    chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    repeat (3) @(negedge clk);
    chk("midrst_no_valid", 128'(bus.out_valid), 128'(0));
    op_w[0] = 20'd5;
    send_op(1, 0, 1'b1, 10'd5);
    wait_drain();

    // Out-of-range residue makes range_err sticky until reset
    force_bad = 1'b1;
    op_w[0] = 20'd7;
    send_op(1, 0, 1'b0, 10'd0);
    wait_drain();
    force_bad = 1'b0;
    op_w[0] = 20'd9;
    send_op(1, 0, 1'b0, 10'd0);
    op_w[0] = 20'd123; op_w[1] = 20'd456; op_w[2] = 20'd789;
    send_op(3, 1, 1'b0, 10'd0);
    wait_drain();
    chk("range_sticky", 128'(range_err), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rng_model = 1'b0;
    chk("range_cleared", 128'(range_err), 128'(0));

    // Randomised operands with random gaps and back-pressure
    rmode = 2;
    for (int i = 0; i < 40; i++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int k = 0; k < 8; k++) op_w[k] = 20'($urandom);
      send_op(n, 2, 1'b0, 10'd0);
    end
    wait_drain();
    rmode = 0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(q.size()), 128'(0));
    chk("proto_count", 128'(proto_seen), 128'(proto_exp));
    chk("range_final", 128'(range_err), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/x_100_mod_997_stream.md
Name: x_100_mod_997_stream

Overview:
- Streaming front/back end for the combinational 100-bit mod-997 reducer.
- Collects a 100-bit operand from a 20-bit valid/ready word stream and drives it to the reducer on `x_out`.
- Registers the reducer's 10-bit residue from `r_in` and presents it on a valid/ready output port.
- Sits directly upstream and downstream of the reducer instance; the reducer is instantiated alongside, not inside, this block.

Parameters:
- WORD_W, 20, input word width in bits
- N_WORDS, 5, words per full operand (WORD_W*N_WORDS = 100)
- R_W, 10, residue width
- MODULUS, 997, modulus used for the residue range check

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts the input word this cycle
- in_data  input  WORD_W  operand word; first word is least significant
- in_last  input  1  marks final word of the operand
- x_out  output  WORD_W*N_WORDS  assembled operand, registered, to the reducer input
- r_in  input  R_W  residue returned by the reducer (combinational function of `x_out`)
- out_valid  output  1  residue valid
- out_ready  input  1  downstream accepts the residue
- out_residue  output  R_W  registered residue
- proto_err  output  1  one-cycle pulse: operand longer than N_WORDS words
- range_err  output  1  sticky: captured `r_in` >= MODULUS

Behaviour:
- Reset: synchronous active-low. While `rst_n`=0 at a clock edge, all of the following are cleared:
  - state = COLLECT, word index = 0
  - `x_out` = 0, `out_residue` = 0
  - `out_valid` = 0, `proto_err` = 0, `range_err` = 0
  - Reset mid-operation discards any partial operand or pending residue; no output is produced for it.
- Input handshake: a word transfers when `in_valid` && `in_ready`.
  - `in_ready` = 1 only in COLLECT and DRAIN.
- COLLECT:
  - Accepted word k is written to `x_out` bits [WORD_W*(k+1)-1 : WORD_W*k].
  - Accepting word 0 also clears all higher slots, so short operands are zero-extended.
  - `in_last` on word k (k < N_WORDS) -> go to REDUCE; index returns to 0.
  - Word N_WORDS-1 accepted without `in_last` -> operand closes as is, `proto_err` pulses next cycle, go to DRAIN.
- DRAIN:
  - Accept and discard words until one with `in_last` is accepted, then go to REDUCE.
  - `x_out` is unchanged.
- REDUCE: exactly one cycle. `x_out` is stable, `r_in` has settled.
  - Capture `out_residue` <= `r_in`.
  - Set `range_err` if `r_in` >= MODULUS; it stays set until reset.
  - Go to HOLD.
- HOLD:
  - `out_valid` = 1 and `out_residue` is held stable until `out_valid` && `out_ready`.
  - On transfer: `out_valid` = 0 next cycle, go to COLLECT.
  - `out_valid` is never dropped without a transfer.
- Latency: final word accepted at edge t -> `x_out` valid after t -> residue captured at edge t+1 -> `out_valid` = 1 after t+1.
  - Minimum cycles per 5-word operand: 5 + 1 + 1 (with `out_ready` held at 1).
- No input is accepted in REDUCE or HOLD. The upstream stalls; this gives single-operand buffering.
- `x_out` holds the last operand until word 0 of the next operand is accepted.
- `in_data` and `in_last` are don't-care when `in_valid` = 0.
- Arithmetic: the block performs none. The residue comes solely from the reducer; MODULUS is used only for the compare.

Test Plan:
- Single word 1000 with `in_last`, `out_ready`=1 -> `x_out`=1000, `out_residue`=3, `out_valid` 2 cycles after acceptance.
- Five words {0,1,0,0,0} (word1=1, i.e. X=2^20), `in_last` on word 4 -> residue 729; then five words {0,0,0,0,1} (X=2^80) -> residue 603, with upper slots correctly replaced.
- `out_ready`=0 for 10 cycles after `out_valid` -> `out_residue` stable, `in_ready`=0 throughout; `out_ready`=1 -> single transfer, `in_ready`=1 next cycle.
- Six words with `in_last` only on word 6, words 1-5 = {997,0,0,0,0} -> `proto_err` pulses once, word 6 discarded, residue 0.
- `rst_n`=0 after 3 words of an operand -> `x_out`=0, no `out_valid`; the next single-word operand 5 -> residue 5.
- Reducer model forced to return 1000 -> `range_err` sets and remains set across subsequent good operands until reset.
